conv_subblock_reader: RTL and testbench

Drains the three encoded sub-block streams (d0/d1/d2) from the convolutional encoder's output buffers once the encoder signals `computation_done`. Issues `rdreq_subblock` one byte-triple at a time and re-emits the bytes as a single interleaved byte stream (q0, q1, q2, q0, …) over a valid/ready handshake. Sits between `convEncoder_bs` and the downstream rate-matching / sub-block interleaver.

---
 rtl/conv_subblock_reader.sv | 170 +++++++++++++++++
 tb/tb_conv_subblock_reader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_subblock_reader.sv
// conv_subblock_reader
// Pops one byte-triple at a time from the convolutional encoder's three
// sub-block buffers and re-emits it as an interleaved byte stream
// (q0, q1, q2, q0, ...) over a valid/ready handshake.
// Optional block counter: define CONV_READER_STATS_EN to add the blk_count port.
//
// state  | meaning
// IDLE   | waiting for computation_done; latches block size on start
// REQ    | rdreq_subblock high for one cycle
// WAIT   | encoder bytes valid; capture into h0..h2
// EMIT0  | present h0 (stream 0) until accepted
// EMIT1  | present h1 (stream 1) until accepted
// EMIT2  | present h2 (stream 2) until accepted; advance byte count
// DONE   | block finished; wait for computation_done to drop
module conv_subblock_reader #(
  parameter int SHORT_BYTES = 132,
  parameter int LONG_BYTES  = 768
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       computation_done,
  input  logic       code_block_length,
  input  logic [7:0] q0,
  input  logic [7:0] q1,
  input  logic [7:0] q2,
  output logic       rdreq_subblock,
  output logic [7:0] out_data,
  output logic [1:0] out_stream,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy
`ifdef CONV_READER_STATS_EN
  ,
  output logic [15:0] blk_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_EMIT0 = 3'd3,
    S_EMIT1 = 3'd4,
    S_EMIT2 = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic       len_sel_q, len_sel_d;
  logic [9:0] byte_cnt_q, byte_cnt_d;
  logic [7:0] h0_q, h0_d;
  logic [7:0] h1_q, h1_d;
  logic [7:0] h2_q, h2_d;
  logic [9:0] n_bytes;
  logic [9:0] n_last;
  logic [9:0] byte_cnt_inc;

`ifdef CONV_READER_STATS_EN
  logic [15:0] blk_cnt_q, blk_cnt_d;
  assign blk_count = blk_cnt_q;
`endif

  // Block length is fixed for the whole block by the value latched at start.
  assign n_bytes      = len_sel_q ? 10'(LONG_BYTES) : 10'(SHORT_BYTES);
  assign n_last       = n_bytes - 10'd1;
  assign byte_cnt_inc = byte_cnt_q + 10'd1;

  // State and datapath registers; reset aborts any block in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      len_sel_q  <= 1'b0;
      byte_cnt_q <= 10'd0;
      h0_q       <= 8'd0;
      h1_q       <= 8'd0;
      h2_q       <= 8'd0;
`ifdef CONV_READER_STATS_EN
      blk_cnt_q  <= 16'd0;
`endif
    end else begin
      state_q    <= state_d;
      len_sel_q  <= len_sel_d;
      byte_cnt_q <= byte_cnt_d;
      h0_q       <= h0_d;
      h1_q       <= h1_d;
      h2_q       <= h2_d;
`ifdef CONV_READER_STATS_EN
      blk_cnt_q  <= blk_cnt_d;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    len_sel_d  = len_sel_q;
    byte_cnt_d = byte_cnt_q;
    h0_d       = h0_q;
    h1_d       = h1_q;
    h2_d       = h2_q;
`ifdef CONV_READER_STATS_EN
    blk_cnt_d  = blk_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (computation_done) begin
          len_sel_d  = code_block_length;
          byte_cnt_d = 10'd0;
          state_d    = S_REQ;
        end
      end
      S_REQ:   state_d = S_WAIT;
      S_WAIT: begin
        h0_d    = q0;
        h1_d    = q1;
        h2_d    = q2;
        state_d = S_EMIT0;
      end
      S_EMIT0: if (out_ready) state_d = S_EMIT1;
      S_EMIT1: if (out_ready) state_d = S_EMIT2;
      S_EMIT2: begin
        if (out_ready) begin
          byte_cnt_d = byte_cnt_inc;
          if (byte_cnt_inc == n_bytes) begin
            state_d = S_DONE;
`ifdef CONV_READER_STATS_EN
            blk_cnt_d = blk_cnt_q + 16'd1;
`endif
          end else begin
            state_d = S_REQ;
          end
        end
      end
      // Stay here while the encoder still reports the old block as ready.
      S_DONE:  if (!computation_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded purely from registered state and holding registers.
  always_comb begin
    rdreq_subblock = (state_q == S_REQ);
    busy           = (state_q != S_IDLE);
    out_valid      = 1'b0;
    out_data       = 8'd0;
    out_stream     = 2'd0;
    out_last       = 1'b0;
    case (state_q)
      S_EMIT0: begin
        out_valid  = 1'b1;
        out_data   = h0_q;
        out_stream = 2'd0;
      end
      S_EMIT1: begin
        out_valid  = 1'b1;
        out_data   = h1_q;
        out_stream = 2'd1;
      end
      S_EMIT2: begin
        out_valid  = 1'b1;
        out_data   = h2_q;
        out_stream = 2'd2;
        out_last   = (byte_cnt_q == n_last);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_conv_subblock_reader.sv
// Testbench for conv_subblock_reader: encoder buffer model feeding q0..q2,
// scoreboard of expected output bytes filled on every rdreq_subblock pulse.
module tb_conv_subblock_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       computation_done;
  logic       code_block_length;
  logic [7:0] q0, q1, q2;
  logic       rdreq_subblock;
  logic [7:0] out_data;
  logic [1:0] out_stream;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
`ifdef CONV_READER_STATS_EN
  logic [15:0] blk_count;
`endif

  always #5 clk = ~clk;

  conv_subblock_reader dut (
    .clk               (clk),
    .reset             (reset),
    .computation_done  (computation_done),
    .code_block_length (code_block_length),
    .q0                (q0),
    .q1                (q1),
    .q2                (q2),
    .rdreq_subblock    (rdreq_subblock),
    .out_data          (out_data),
    .out_stream        (out_stream),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_last          (out_last),
    .busy              (busy)
`ifdef CONV_READER_STATS_EN
    ,
    .blk_count         (blk_count)
`endif
  );

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] s;
    logic       l;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;
  int pops, bytes_seen, lasts, busy_ticks, pop_idx, cur_n, stall_pct;
  logic       pend;
  logic [7:0] pend0, pend1, pend2;
  logic       prev_rdreq, prev_stall;
  logic [7:0] prev_data;
  logic [1:0] prev_stream;
  logic       found;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_block(input logic len);
    cur_n             = len ? 768 : 132;
    pop_idx           = 0;
    pops              = 0;
    bytes_seen        = 0;
    lasts             = 0;
    busy_ticks        = 0;
    code_block_length = len;
    computation_done  = 1'b1;
  endtask

  // One clock: drive inputs after the rising edge, observe on the falling edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (pend) begin
      q0   = pend0;
      q1   = pend1;
      q2   = pend2;
      pend = 1'b0;
    end
    out_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
    @(negedge clk);
    if (busy) busy_ticks++;
    if (!reset) begin
      check("rst_rdreq", rdreq_subblock, 0);
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_data", out_data, 0);
    end
    if (rdreq_subblock) begin
      check("rdreq_back_to_back", prev_rdreq, 0);
      pend0 = 8'(8'h10 + pop_idx);
      pend1 = 8'(8'h20 + pop_idx);
      pend2 = 8'(8'h30 + pop_idx);
      pend  = 1'b1;
      sb.push_back('{d: pend0, s: 2'd0, l: 1'b0});
      sb.push_back('{d: pend1, s: 2'd1, l: 1'b0});
      sb.push_back('{d: pend2, s: 2'd2, l: (pop_idx == cur_n - 1)});
      pop_idx++;
      pops++;
    end
    prev_rdreq = rdreq_subblock;
    if (prev_stall) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, prev_data);
      check("hold_stream", out_stream, prev_stream);
    end
    check("last_without_valid", out_last && !out_valid, 0);
    if (out_valid && out_ready) begin
      check("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out_data", out_data, e.d);
        check("out_stream", out_stream, e.s);
        check("out_last", out_last, e.l);
      end
      bytes_seen++;
      if (out_last) lasts++;
    end
    prev_stall  = out_valid && !out_ready;
    prev_data   = out_data;
    prev_stream = out_stream;
  endtask

  initial begin
    reset             = 1'b0;
    computation_done  = 1'b0;
    code_block_length = 1'b0;
    out_ready         = 1'b1;
    q0 = 8'd0; q1 = 8'd0; q2 = 8'd0;
    pend = 1'b0; prev_rdreq = 1'b0; prev_stall = 1'b0;
    prev_data = 8'd0; prev_stream = 2'd0;
    stall_pct = 0;
    found = 1'b0;

    // Reset held with computation_done high: nothing may happen.
    start_block(1'b0);
    repeat (3) tick();
    check("rst_pops", pops, 0);
    check("rst_stream", out_stream, 0);
    check("rst_last", out_last, 0);
`ifdef CONV_READER_STATS_EN
    check("rst_blk_count", blk_count, 0);
`endif

    // Release: rdreq one cycle later, first out_valid two cycles after that.
    reset = 1'b1;
    tick();
    check("start_rdreq", rdreq_subblock, 1);
    tick();
    check("start_wait_valid", out_valid, 0);
    tick();
    check("first_valid", out_valid, 1);
    check("first_byte", out_data, 8'h10);
    repeat (10) tick();
    computation_done = 1'b0;
    for (int i = 0; i < 2000 && (busy || bytes_seen < 396); i++) tick();
    check("short_bytes", bytes_seen, 396);
    check("short_pops", pops, 132);
    check("short_lasts", lasts, 1);
    check("short_cycles", busy_ticks, 5 * 132 + 1);
    check("short_idle", busy, 0);
    check("short_sb_empty", sb.size(), 0);
`ifdef CONV_READER_STATS_EN
    check("blk_count_1", blk_count, 1);
`endif

    // Long block; size select changed after start must be ignored.
    start_block(1'b1);
    tick();
    code_block_length = 1'b0;
    for (int i = 0; i < 5000 && bytes_seen < 2304; i++) tick();
    check("long_bytes_in_time", bytes_seen, 2304);
    repeat (20) tick();
    check("long_pops", pops, 768);
    check("long_bytes", bytes_seen, 2304);
    check("long_lasts", lasts, 1);
    check("long_stays_done", busy, 1);
    check("long_sb_empty", sb.size(), 0);
`ifdef CONV_READER_STATS_EN
    check("blk_count_2", blk_count, 2);
`endif
    computation_done = 1'b0;
    repeat (2) tick();
    check("long_idle", busy, 0);

    // Backpressure: ~30% of cycles not ready.
    stall_pct = 30;
    start_block(1'b0);
    repeat (15) tick();
    computation_done = 1'b0;
    for (int i = 0; i < 4000 && (busy || bytes_seen < 396); i++) tick();
    check("bp_bytes", bytes_seen, 396);
    check("bp_pops", pops, 132);
    check("bp_lasts", lasts, 1);
    check("bp_idle", busy, 0);
    check("bp_sb_empty", sb.size(), 0);
    stall_pct = 0;
`ifdef CONV_READER_STATS_EN
    check("blk_count_3", blk_count, 3);
`endif

    // Reset during EMIT1 of triple 50 aborts at once.
    start_block(1'b0);
    for (int i = 0; i < 400 && !found; i++) begin
      tick();
      if (pops == 51 && out_valid && out_stream == 2'd1) found = 1'b1;
    end
    check("reached_triple50_emit1", found, 1);
    reset = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_data", out_data, 0);
    check("abort_stream", out_stream, 0);
    check("abort_busy", busy, 0);
    check("abort_rdreq", rdreq_subblock, 0);
    sb.delete();
    pend = 1'b0; prev_stall = 1'b0; prev_rdreq = 1'b0;
    repeat (3) tick();
    check("abort_no_pops", pops, 51);
`ifdef CONV_READER_STATS_EN
    check("abort_blk_count", blk_count, 0);
`endif

    // Restart reads a fresh block from byte 0.
    start_block(1'b0);
    reset = 1'b1;
    tick();
    check("restart_rdreq", rdreq_subblock, 1);
    repeat (10) tick();
    computation_done = 1'b0;
    for (int i = 0; i < 2000 && (busy || bytes_seen < 396); i++) tick();
    check("restart_bytes", bytes_seen, 396);
    check("restart_pops", pops, 132);
    check("restart_lasts", lasts, 1);
    check("restart_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
